// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - direct-mapped instruction cache with line-refill controller
//
// Purpose: serves IF-stage fetches by PC from a direct-mapped cache. A hit is
// combinational in the same cycle. A miss starts a refill of the whole line
// from instruction memory, one word per beat, in address order.
//
// Ports:
//   i_Clk, i_Rst_n     clock (rising edge), asynchronous active-low reset
//   i_PC, i_Read_En    fetch byte address and fetch request
//   i_Flush            invalidate all lines (single-cycle pulse)
//   o_Instr            instruction word, valid when i_Read_En=1 and o_ICache_Miss=0
//   o_ICache_Miss      fetch cannot be served this cycle (stalls PC, flushes IFID)
//   o_Mem_Req          refill request, held high for the whole refill
//   o_Mem_Addr         byte address of the word currently requested
//   i_Mem_Valid        beat strobe: i_Mem_Data is the word at o_Mem_Addr
//   i_Mem_Data         refill data
//   o_Miss_Count       saturating count of refills started
module icache_refill_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINES  = 16,
  parameter int WORDS  = 4
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic [ADDR_W-1:0] i_PC,
  input  logic              i_Read_En,
  input  logic              i_Flush,
  output logic [DATA_W-1:0] o_Instr,
  output logic              o_ICache_Miss,
  output logic              o_Mem_Req,
  output logic [ADDR_W-1:0] o_Mem_Addr,
  input  logic              i_Mem_Valid,
  input  logic [DATA_W-1:0] i_Mem_Data,
  output logic [15:0]       o_Miss_Count
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t              r_State;
  logic [LINES-1:0]    r_Valid;
  logic [TAG_W-1:0]    r_Tag_Arr  [LINES];
  logic [DATA_W-1:0]   r_Data_Arr [LINES*WORDS];
  logic [IDX_W-1:0]    r_Fill_Idx;
  logic [TAG_W-1:0]    r_Fill_Tag;
  logic [OFF_W-1:0]    r_Beat;
  logic                r_Drop;

  logic [OFF_W-1:0]    w_Off;
  logic [IDX_W-1:0]    w_Idx;
  logic [TAG_W-1:0]    w_Tag;
  logic                w_Hit;
  logic                w_Start;
  logic                w_Beat_Wr;
  logic                w_Last;
  logic [ADDR_W-1:0]   w_Line_Base;
  logic                w_unused_byte;

  assign w_Off       = i_PC[2 +: OFF_W];
  assign w_Idx       = i_PC[2+OFF_W +: IDX_W];
  assign w_Tag       = i_PC[ADDR_W-1 -: TAG_W];
  assign w_Line_Base = {i_PC[ADDR_W-1:OFF_W+2], {(OFF_W+2){1'b0}}};
  assign w_unused_byte = &{1'b0, i_PC[1:0]};

  assign w_Hit     = r_Valid[w_Idx] & (r_Tag_Arr[w_Idx] == w_Tag);
  // A flush in the same cycle wins over starting a refill; the miss persists
  // and the refill starts the next cycle.
  assign w_Start   = (r_State == S_IDLE) & i_Read_En & ~w_Hit & ~i_Flush;
  assign w_Beat_Wr = (r_State == S_FILL) & i_Mem_Valid;
  assign w_Last    = (r_Beat == OFF_W'(WORDS-1));

  // Forced low during reset so the hazard logic does not stall on X/cold state.
  assign o_ICache_Miss = i_Rst_n & ((r_State == S_FILL) | (i_Read_En & ~w_Hit));
  assign o_Instr       = r_Data_Arr[{w_Idx, w_Off}];

  // Tag/data storage is deliberately not reset; validity is tracked by r_Valid.
  always_ff @(posedge i_Clk) begin
    if (w_Beat_Wr) begin
      r_Data_Arr[{r_Fill_Idx, r_Beat}] <= i_Mem_Data;
      if (w_Last) begin
        r_Tag_Arr[r_Fill_Idx] <= r_Fill_Tag;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_State      <= S_IDLE;
      r_Valid      <= '0;
      r_Fill_Idx   <= '0;
      r_Fill_Tag   <= '0;
      r_Beat       <= '0;
      r_Drop       <= 1'b0;
      o_Mem_Req    <= 1'b0;
      o_Mem_Addr   <= '0;
      o_Miss_Count <= '0;
    end else begin
      if (i_Flush) begin
        r_Valid <= '0;
      end
      case (r_State)
        S_IDLE: begin
          if (w_Start) begin
            r_State    <= S_FILL;
            r_Fill_Idx <= w_Idx;
            r_Fill_Tag <= w_Tag;
            r_Beat     <= '0;
            r_Drop     <= 1'b0;
            o_Mem_Req  <= 1'b1;
            o_Mem_Addr <= w_Line_Base;
            if (o_Miss_Count != 16'hFFFF) begin
              o_Miss_Count <= o_Miss_Count + 16'd1;
            end
          end
        end
        S_FILL: begin
          // A flush mid-refill lets the burst finish so the memory side stays
          // aligned, but the line must not become valid with stale contents.
          if (i_Flush) begin
            r_Drop <= 1'b1;
          end
          if (i_Mem_Valid) begin
            r_Beat     <= r_Beat + OFF_W'(1);
            o_Mem_Addr <= o_Mem_Addr + ADDR_W'(4);
            if (w_Last) begin
              if (!r_Drop && !i_Flush) begin
                r_Valid[r_Fill_Idx] <= 1'b1;
              end
              r_Drop    <= 1'b0;
              o_Mem_Req <= 1'b0;
              r_State   <= S_IDLE;
            end
          end
        end
        default: r_State <= S_IDLE;
      endcase
    end
  end

endmodule
